// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants.
//   UART_DATA_BITS  - default byte width for UART datapaths
//   tx_fifo_state_t - states of the transmit FIFO drain FSM
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } tx_fifo_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: circular single-clock FIFO used as the UART transmit queue.
//   clk, rst  - clock and synchronous active-high reset
//   push      - enqueue wr_data (ignored while full)
//   pop       - dequeue the head entry (ignored while empty)
//   wr_data   - byte to enqueue
//   rd_data   - current head entry (mem[rd_ptr]); valid while !empty
//   count     - occupancy, 0..DEPTH
//   empty     - count == 0
//   full      - count == DEPTH
module uart_sync_fifo #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_BITS-1:0]   wr_data,
  output logic [DATA_BITS-1:0]   rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  // Full blocks a push even when a pop happens on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointer wrap is the natural AW-bit overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue between the echo logic and the UART transmitter.
// Bytes written on a valid/ready port are queued and handed to the
// transmitter one at a time through a tx_start/tx_data/tx_busy handshake.
//   clk, rst  - clock and synchronous active-high reset
//   wr_valid  - write request; byte taken when wr_valid && wr_ready
//   wr_data   - byte to enqueue
//   wr_ready  - !full
//   tx_start  - registered one-cycle pulse per byte handed to the transmitter
//   tx_data   - registered byte, held until the next pop
//   tx_busy   - transmitter busy flag
//   count     - occupancy, 0..DEPTH
//   empty     - count == 0
//   full      - count == DEPTH
//   overflow  - sticky: a write was attempted while full (cleared by rst)
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = UART_DATA_BITS,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  input  logic [DATA_BITS-1:0]   wr_data,
  output logic                   wr_ready,
  output logic                   tx_start,
  output logic [DATA_BITS-1:0]   tx_data,
  input  logic                   tx_busy,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow
);

  localparam int unsigned TW = $clog2(BUSY_TIMEOUT) + 1;

  tx_fifo_state_t       state;
  tx_fifo_state_t       state_next;
  logic [TW-1:0]        timer;
  logic [TW-1:0]        timer_next;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  assign wr_ready = !full;
  assign push     = wr_valid && !full;

  uart_sync_fifo #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (head),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  // WAIT_BUSY gives the transmitter BUSY_TIMEOUT cycles to raise tx_busy;
  // if it never does, the byte is treated as sent so the queue cannot stall.
  always_comb begin
    state_next = state;
    timer_next = timer;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop        = 1'b1;
          state_next = WAIT_BUSY;
          timer_next = '0;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
          timer_next = '0;
        end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
          state_next = IDLE;
          timer_next = '0;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_start <= 1'b0;
      tx_data  <= '0;
      overflow <= 1'b0;
    end else begin
      tx_start <= pop;
      if (pop) tx_data <= head;
      if (wr_valid && full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int unsigned DATA_BITS    = 8;
  localparam int unsigned DEPTH        = 16;
  localparam int unsigned BUSY_TIMEOUT = 4;
  localparam int unsigned CW           = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 wr_valid;
  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_ready;
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_busy;
  logic [CW-1:0]        count;
  logic                 empty;
  logic                 full;
  logic                 overflow;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DATA_BITS    (DATA_BITS),
    .DEPTH        (DEPTH),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Transmitter model: tx_busy rises the cycle after tx_start and stays
  // high for busy_len cycles.
  bit   model_on = 1'b0;
  int   busy_len = 10;
  int   tx_left  = 0;
  int   starts   = 0;
  logic [7:0] got [$];

  task automatic step();
    @(posedge clk);
    #1;
    if (tx_start === 1'b1) starts++;
    if (model_on) begin
      if (tx_start === 1'b1) begin
        got.push_back(tx_data);
        tx_busy = 1'b0;
        tx_left = busy_len;
      end else if (tx_left > 0) begin
        tx_busy = 1'b1;
        tx_left--;
      end else begin
        tx_busy = 1'b0;
      end
    end
  endtask

  typedef struct {
    logic       rst;
    logic       wv;
    logic [7:0] wd;
    logic       busy;
    logic       ready;
    logic       start;
    logic [7:0] data;
    int         cnt;
    logic       emp;
    logic       ful;
    logic       ovf;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input logic r, input logic wv, input logic [7:0] wd,
                              input logic b, input logic rdy, input logic st,
                              input logic [7:0] d, input int c, input logic e,
                              input logic f, input logic o);
    vec_t t;
    t.rst = r; t.wv = wv; t.wd = wd; t.busy = b;
    t.ready = rdy; t.start = st; t.data = d; t.cnt = c;
    t.emp = e; t.ful = f; t.ovf = o;
    return t;
  endfunction

  initial begin
    int sent;
    bit ovf_seen;
    int budget;

    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; tx_busy = 1'b0;

    // Single byte with a 10-cycle busy transmitter, a byte queued during
    // busy, then the busy-timeout path with 0x3C/0x3D.
    //              rst wv  wd     busy | rdy st data   cnt emp ful ovf
    tbl.push_back(mk(1, 0, 8'h00, 0,     1, 0, 8'h00, 0,  1,  0,  0));
    tbl.push_back(mk(0, 1, 8'hA5, 0,     1, 0, 8'h00, 1,  0,  0,  0));
    tbl.push_back(mk(0, 0, 8'h00, 0,     1, 1, 8'hA5, 0,  1,  0,  0));
    tbl.push_back(mk(0, 0, 8'h00, 0,     1, 0, 8'hA5, 0,  1,  0,  0));
    tbl.push_back(mk(0, 0, 8'h00, 1,     1, 0, 8'hA5, 0,  1,  0,  0));
    tbl.push_back(mk(0, 1, 8'h5A, 1,     1, 0, 8'hA5, 1,  0,  0,  0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 0, 8'h00, 1,   1, 0, 8'hA5, 1,  0,  0,  0));
    tbl.push_back(mk(0, 0, 8'h00, 0,     1, 0, 8'hA5, 1,  0,  0,  0));
    tbl.push_back(mk(0, 0, 8'h00, 0,     1, 1, 8'h5A, 0,  1,  0,  0));
    tbl.push_back(mk(0, 1, 8'h3C, 0,     1, 0, 8'h5A, 1,  0,  0,  0));
    tbl.push_back(mk(0, 1, 8'h3D, 0,     1, 0, 8'h5A, 2,  0,  0,  0));
    tbl.push_back(mk(0, 0, 8'h00, 0,     1, 0, 8'h5A, 2,  0,  0,  0));
    tbl.push_back(mk(0, 0, 8'h00, 0,     1, 0, 8'h5A, 2,  0,  0,  0));
    tbl.push_back(mk(0, 0, 8'h00, 0,     1, 1, 8'h3C, 1,  0,  0,  0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 0, 8'h00, 0,   1, 0, 8'h3C, 1,  0,  0,  0));
    tbl.push_back(mk(0, 0, 8'h00, 0,     1, 1, 8'h3D, 0,  1,  0,  0));
    tbl.push_back(mk(0, 0, 8'h00, 0,     1, 0, 8'h3D, 0,  1,  0,  0));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; wr_valid = tbl[i].wv; wr_data = tbl[i].wd; tx_busy = tbl[i].busy;
      step();
      chk($sformatf("vec%0d.wr_ready", i), wr_ready, tbl[i].ready);
      chk($sformatf("vec%0d.tx_start", i), tx_start, tbl[i].start);
      chk($sformatf("vec%0d.tx_data", i),  tx_data,  tbl[i].data);
      chk($sformatf("vec%0d.count", i),    count,    tbl[i].cnt);
      chk($sformatf("vec%0d.empty", i),    empty,    tbl[i].emp);
      chk($sformatf("vec%0d.full", i),     full,     tbl[i].ful);
      chk($sformatf("vec%0d.overflow", i), overflow, tbl[i].ovf);
    end

    // Burst into a blocked transmitter: 16 accepted, rest dropped.
    rst = 1'b0; tx_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic [7:0] b;
      b = 8'(i);
      wr_valid = 1'b1; wr_data = b;
      step();
      if (i == 15) begin
        chk("burst.full16", full, 1);
        chk("burst.ready16", wr_ready, 0);
        chk("burst.count16", count, 16);
        chk("burst.ovf16", overflow, 0);
      end
      if (i == 16) begin
        chk("burst.ovf17", overflow, 1);
        chk("burst.count17", count, 16);
      end
    end
    wr_valid = 1'b0;
    got.delete();
    busy_len = 5; tx_left = 0; tx_busy = 1'b0; model_on = 1'b1;
    budget = 0;
    while (got.size() < 16 && budget < 1000) begin step(); budget++; end
    chk("burst.drained", got.size(), 16);
    for (int k = 0; k < got.size() && k < 16; k++)
      chk($sformatf("burst.byte%0d", k), got[k], k);
    repeat (20) step();
    model_on = 1'b0; tx_busy = 1'b0;
    step();
    chk("burst.count_end", count, 0);
    chk("burst.ovf_sticky", overflow, 1);

    // Reset while in WAIT_DONE with 6 bytes queued.
    for (int i = 0; i < 7; i++) begin
      wr_valid = 1'b1; wr_data = 8'h70 + 8'(i); tx_busy = (i >= 2);
      step();
    end
    wr_valid = 1'b0;
    chk("rstmid.count_before", count, 6);
    rst = 1'b1;
    step();
    rst = 1'b0; tx_busy = 1'b0;
    chk("rstmid.count", count, 0);
    chk("rstmid.empty", empty, 1);
    chk("rstmid.overflow", overflow, 0);
    chk("rstmid.tx_start", tx_start, 0);
    chk("rstmid.tx_data", tx_data, 0);
    chk("rstmid.wr_ready", wr_ready, 1);
    starts = 0;
    repeat (15) step();
    chk("rstmid.no_start", starts, 0);
    wr_valid = 1'b1; wr_data = 8'h7E;
    step();
    wr_valid = 1'b0;
    chk("rstmid.new_start_early", tx_start, 0);
    step();
    chk("rstmid.new_start", tx_start, 1);
    chk("rstmid.new_data", tx_data, 8'h7E);
    repeat (8) step();

    // Push and pop on the same edge at count 5.
    tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = 8'h60 + 8'(i);
      step();
    end
    chk("simul.count_before", count, 5);
    wr_valid = 1'b1; wr_data = 8'h65; tx_busy = 1'b0;
    step();
    wr_valid = 1'b0;
    chk("simul.count", count, 5);
    chk("simul.tx_start", tx_start, 1);
    chk("simul.tx_data", tx_data, 8'h60);
    got.delete();
    busy_len = 4; tx_left = busy_len; model_on = 1'b1;
    budget = 0;
    while (got.size() < 5 && budget < 500) begin step(); budget++; end
    chk("simul.drained", got.size(), 5);
    for (int k = 0; k < got.size() && k < 5; k++)
      chk($sformatf("simul.byte%0d", k), got[k], 8'h61 + 8'(k));
    repeat (20) step();

    // Wrap-around stream of 40 bytes with a 10-cycle transmitter.
    got.delete();
    busy_len = 10; sent = 0; ovf_seen = 1'b0;
    budget = 0;
    while (got.size() < 40 && budget < 5000) begin
      if (sent < 40 && count < 8) begin
        wr_valid = 1'b1; wr_data = 8'h30 + 8'(sent); sent++;
      end else begin
        wr_valid = 1'b0;
      end
      step();
      if (overflow !== 1'b0) ovf_seen = 1'b1;
      budget++;
    end
    wr_valid = 1'b0;
    chk("wrap.received", got.size(), 40);
    for (int k = 0; k < got.size() && k < 40; k++)
      chk($sformatf("wrap.byte%0d", k), got[k], 8'h30 + 8'(k));
    chk("wrap.overflow", ovf_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
